// File: rtl/fft_pkg.sv
// Shared constants and types for the memory-based FFT control path.
//   BF_LATENCY  : butterfly datapath pipeline depth (cycles)
//   MEM_LATENCY : sample RAM / twiddle ROM synchronous read latency (cycles)
//   WB_DELAY    : cycles from read issue to write-back of the same pair
//   seq_state_e : sequencer FSM states
package fft_pkg;

  localparam int BF_LATENCY  = 3;
  localparam int MEM_LATENCY = 1;
  localparam int WB_DELAY    = BF_LATENCY + MEM_LATENCY;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr0, addr1} from the read-issue
// cycle to the cycle the butterfly results appear.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low clear
//   vld_i, addr0_i/1_i : read issue strobe and operand address pair
//   vld_o, addr0_o/1_o : same values DEPTH cycles later (write strobe/addresses)
module fft_wb_delay #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vld_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  output logic          vld_o,
  output logic [AW-1:0] addr0_o,
  output logic [AW-1:0] addr1_o
);

  logic [DEPTH-1:0]         vld_pipe_q;
  logic [DEPTH-1:0][AW-1:0] a0_pipe_q;
  logic [DEPTH-1:0][AW-1:0] a1_pipe_q;

  // Entry 0 is loaded every cycle; entry DEPTH-1 is the output tap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      a0_pipe_q  <= '0;
      a1_pipe_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[DEPTH-2:0], vld_i};
      a0_pipe_q  <= {a0_pipe_q[DEPTH-2:0], addr0_i};
      a1_pipe_q  <= {a1_pipe_q[DEPTH-2:0], addr1_i};
    end
  end

  assign vld_o   = vld_pipe_q[DEPTH-1];
  assign addr0_o = a0_pipe_q[DEPTH-1];
  assign addr1_o = a1_pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bf_sequencer.sv
// Address/control sequencer for the shared radix-2 DIT butterfly. Walks all
// LOG2N stages in place, issuing N/2 operand-pair reads plus twiddle address
// per stage, drains the butterfly pipeline between stages, and issues the
// matching write-backs WB_DELAY cycles after each read.
// Ports:
//   clk, rst (async, active low), start  : control inputs
//   busy, done                           : run status (done is a 1-cycle pulse)
//   rd_en, rd_addr0, rd_addr1, tw_addr   : operand read + twiddle ROM address
//   wr_en, wr_addr0, wr_addr1            : result write-back
//   stage                                : current stage index (debug)
// Optional build macro FFT_SEQ_INVERSE_EN adds input `inverse` (latched on
// start) and output `tw_conj` (held for the run) for IFFT operation.
module fft_bf_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = 4,
  parameter int AW    = LOG2N,
  parameter int TW_AW = LOG2N - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr0,
  output logic [AW-1:0]    rd_addr1,
  output logic [TW_AW-1:0] tw_addr,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr0,
  output logic [AW-1:0]    wr_addr1,
  output logic [LOG2N-1:0] stage
`ifdef FFT_SEQ_INVERSE_EN
  ,
  input  logic             inverse,
  output logic             tw_conj
`endif
);

  localparam int KW     = LOG2N - 1;
  localparam int HALF_N = 1 << (LOG2N - 1);
  localparam int DW     = $clog2(WB_DELAY + 1);

  localparam logic [KW-1:0]    K_LAST = KW'(HALF_N - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

  // Lower operand of butterfly k in stage s: the k-th index whose bit s is 0.
  function automatic logic [AW-1:0] pair_lo(input logic [KW-1:0] k,
                                            input logic [LOG2N-1:0] s);
    logic [AW-1:0] kk;
    logic [AW-1:0] j;
    kk = AW'(k);
    j  = kk & ((AW'(1) << s) - AW'(1));
    return ((kk >> s) << (s + 1'b1)) + j;
  endfunction

  function automatic logic [AW-1:0] pair_hi(input logic [KW-1:0] k,
                                            input logic [LOG2N-1:0] s);
    return pair_lo(k, s) + (AW'(1) << s);
  endfunction

  // Twiddle exponent j * N/(2*half), expressed as a shift of j.
  function automatic logic [TW_AW-1:0] tw_of(input logic [KW-1:0] k,
                                             input logic [LOG2N-1:0] s);
    logic [AW-1:0] j;
    j = AW'(k) & ((AW'(1) << s) - AW'(1));
    return TW_AW'(j << (LOG2N - 1 - int'(s)));
  endfunction

  seq_state_e       state_q;
  logic [KW-1:0]    k_q, k_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [DW-1:0]    drain_q;
  logic             busy_q, done_q, rd_en_q;
  logic [AW-1:0]    rd_addr0_q, rd_addr1_q, rd_addr0_d, rd_addr1_d;
  logic [TW_AW-1:0] tw_addr_q, tw_addr_d;
`ifdef FFT_SEQ_INVERSE_EN
  logic             tw_conj_q;
`endif

  // Index of the next read to issue, should the FSM decide to issue one.
  // In DRAIN on the last stage stage_d wraps past the end; the resulting
  // addresses are never loaded because the FSM goes to DONE instead.
  always_comb begin
    k_d     = k_q;
    stage_d = stage_q;
    unique case (state_q)
      S_IDLE: begin
        k_d     = '0;
        stage_d = '0;
      end
      S_ISSUE: k_d = k_q + 1'b1;
      S_DRAIN: begin
        k_d     = '0;
        stage_d = stage_q + 1'b1;
      end
      default: ;
    endcase
    rd_addr0_d = pair_lo(k_d, stage_d);
    rd_addr1_d = pair_hi(k_d, stage_d);
    tw_addr_d  = tw_of(k_d, stage_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_addr_q  <= '0;
`ifdef FFT_SEQ_INVERSE_EN
      tw_conj_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_ISSUE;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            k_q        <= k_d;
            stage_q    <= stage_d;
            rd_addr0_q <= rd_addr0_d;
            rd_addr1_q <= rd_addr1_d;
            tw_addr_q  <= tw_addr_d;
`ifdef FFT_SEQ_INVERSE_EN
            tw_conj_q  <= inverse;
`endif
          end
        end
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= DW'(WB_DELAY);
          end else begin
            k_q        <= k_d;
            rd_addr0_q <= rd_addr0_d;
            rd_addr1_q <= rd_addr1_d;
            tw_addr_q  <= tw_addr_d;
          end
        end
        S_DRAIN: begin
          // Last drain cycle coincides with the stage's final write-back, so
          // the next stage's first read lands one cycle after it.
          if (drain_q == DW'(1)) begin
            if (stage_q == S_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_ISSUE;
              rd_en_q    <= 1'b1;
              k_q        <= k_d;
              stage_q    <= stage_d;
              rd_addr0_q <= rd_addr0_d;
              rd_addr1_q <= rd_addr1_d;
              tw_addr_q  <= tw_addr_d;
            end
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fft_wb_delay #(
    .AW    (AW),
    .DEPTH (WB_DELAY)
  ) u_wb_delay (
    .clk_i   (clk),
    .rst_ni  (rst),
    .vld_i   (rd_en_q),
    .addr0_i (rd_addr0_q),
    .addr1_i (rd_addr1_q),
    .vld_o   (wr_en),
    .addr0_o (wr_addr0),
    .addr1_o (wr_addr1)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign tw_addr  = tw_addr_q;
  assign stage    = stage_q;
`ifdef FFT_SEQ_INVERSE_EN
  assign tw_conj  = tw_conj_q;
`endif

endmodule
